// File: rtl/lu_pkg.sv
// lu_pkg: shared sizes, complex element/row types and store states for the LU matrix store.
package lu_pkg;
  localparam int LU_SIZE = 4;
  localparam int LU_WIDTH = 64;
  localparam int ADDR_W = $clog2(LU_SIZE);
  localparam int ELEM_W = 2 * LU_WIDTH;
  localparam int ROW_W = LU_SIZE * ELEM_W;
  typedef struct packed {
    logic [LU_WIDTH-1:0] imag;
    logic [LU_WIDTH-1:0] re;
  } cplx_t;
  typedef cplx_t [LU_SIZE-1:0] row_t;
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} lu_store_state_e;
endpackage

// File: rtl/lu_row_ram.sv
// lu_row_ram: row memory with one write port and a registered write-first read port.
module lu_row_ram
  import lu_pkg::*;
#(
  parameter int DEPTH = LU_SIZE,
  parameter int DW = ROW_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem[waddr_i] <= wdata_i;
  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_o <= '0;
    else if (re_i) rdata_o <= (we_i && waddr_i == raddr_i) ? wdata_i : mem[raddr_i];
  end
endmodule

// File: rtl/lu_matrix_store.sv
// lu_matrix_store: loads a complex matrix, serves the LU core's row traffic,
// captures L/U results and drains them downstream.
module lu_matrix_store
  import lu_pkg::*;
#(
  parameter int SIZE = LU_SIZE,
  parameter int WIDTH = LU_WIDTH,
  localparam int AW = $clog2(SIZE),
  localparam int RW = SIZE * 2 * WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          flush_i,
  input  logic [RW-1:0] load_row_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  output logic          lu_start_o,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_addr_valid_i,
  output logic [RW-1:0] rd_row_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          rd_valid_o,
  input  logic [RW-1:0] wr_row_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [RW-1:0] l_col_i,
  input  logic [RW-1:0] u_row_i,
  input  logic [AW-1:0] res_addr_i,
  input  logic          res_valid_i,
  output logic          res_ready_o,
  output logic [RW-1:0] drain_l_o,
  output logic [RW-1:0] drain_u_o,
  output logic [AW-1:0] drain_addr_o,
  output logic          drain_valid_o,
  input  logic          drain_ready_i,
  output logic          busy_o,
  output logic          done_o
);
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
  lu_store_state_e state_q, state_d;
  logic [AW-1:0] load_cnt, res_cnt, drain_cnt;
  logic [RW-1:0] l_mem [SIZE];
  logic [RW-1:0] u_mem [SIZE];
  logic load_beat, wb, rd_en, res_acc, drain_hs;
  // Flush suppresses every same-cycle side effect so it truly wins.
  assign load_beat = state_q == LOAD && load_valid_i && !flush_i;
  assign wb = state_q == RUN && wr_valid_i && !flush_i;
  assign rd_en = state_q == RUN && rd_addr_valid_i && !flush_i;
  assign res_acc = state_q == RUN && res_valid_i && !flush_i;
  assign drain_hs = state_q == DRAIN && drain_ready_i && !flush_i;

  lu_row_ram #(.DEPTH(SIZE), .DW(RW)) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (load_beat || wb),
    .waddr_i (load_beat ? load_cnt : wr_addr_i),
    .wdata_i (load_beat ? load_row_i : wr_row_i),
    .re_i    (rd_en),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_row_o)
  );

  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (load_beat && load_cnt == LAST) state_d = START;
      START:   state_d = RUN;
      RUN:     if (res_acc && res_cnt == LAST) state_d = DRAIN;
      DRAIN:   if (drain_hs && drain_cnt == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    load_ready_o = state_q == LOAD;
    lu_start_o = state_q == START;
    wr_ready_o = state_q == RUN;
    res_ready_o = state_q == RUN;
    drain_valid_o = state_q == DRAIN;
    busy_o = state_q != IDLE;
    drain_addr_o = drain_valid_o ? drain_cnt : '0;
    drain_l_o = drain_valid_o ? l_mem[drain_cnt] : '0;
    drain_u_o = drain_valid_o ? u_mem[drain_cnt] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      load_cnt <= '0;
      res_cnt <= '0;
      drain_cnt <= '0;
      rd_valid_o <= 1'b0;
      rd_addr_o <= '0;
      done_o <= 1'b0;
    end else begin
      load_cnt <= load_beat ? (load_cnt == LAST ? '0 : load_cnt + 1'b1) : load_cnt;
      res_cnt <= res_acc ? (res_cnt == LAST ? '0 : res_cnt + 1'b1) : res_cnt;
      drain_cnt <= drain_hs ? (drain_cnt == LAST ? '0 : drain_cnt + 1'b1) : drain_cnt;
      rd_valid_o <= rd_en;
      rd_addr_o <= rd_en ? rd_addr_i : rd_addr_o;
      done_o <= drain_hs && drain_cnt == LAST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_acc) begin
      l_mem[res_addr_i] <= l_col_i;
      u_mem[res_addr_i] <= u_row_i;
    end
  end
endmodule
